// File: rtl/fc_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected stream controller.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } ld_state_t;

    // Accumulator width of one neuron: full product plus adder-tree growth.
    function automatic int acc_w(input int width, input int in);
        return 2 * width + $clog2(in);
    endfunction

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_result_drain.sv
// Result bank and output stream: holds one captured frame of neuron outputs
// and streams them one per handshake, lowest neuron first.
module fc_result_drain
    import fc_ctrl_pkg::*;
#(
    parameter int N_OUT = 84,
    parameter int ACC_W = 23,
    parameter int IDX_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cap_en,
    input  logic [N_OUT*ACC_W-1:0] z_bus,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   empty,
    output logic                   last_hs
);

    logic [N_OUT-1:0][ACC_W-1:0] res_q;
    logic                        pend_q;
    logic [IDX_W-1:0]            dr_idx;
    logic                        hs;

    assign hs        = pend_q & out_ready;
    assign out_valid = pend_q;
    assign out_idx   = dr_idx;
    assign out_data  = res_q[dr_idx];
    assign out_last  = pend_q && (dr_idx == IDX_W'(N_OUT - 1));
    assign last_hs   = hs & out_last;
    assign empty     = ~pend_q;

    // Capture overrides the final handshake so a new frame follows with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q  <= '0;
            pend_q <= 1'b0;
            dr_idx <= '0;
        end else if (cap_en) begin
            res_q  <= z_bus;
            pend_q <= 1'b1;
            dr_idx <= '0;
        end else if (hs) begin
            if (out_last) begin
                pend_q <= 1'b0;
                dr_idx <= '0;
            end else begin
                dr_idx <= dr_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc_stream_ctrl.sv
// Sequencer around a combinational FC layer: serial load into the activation
// bank, fixed multicycle settle, capture into the result bank, serial drain.
module fc_stream_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int IN     = 128,
    parameter  int N_OUT  = 84,
    parameter  int SETTLE = 2,
    localparam int ACC_W  = acc_w(WIDTH, IN),
    localparam int IDX_W  = idx_w(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic [IN*WIDTH-1:0]    x_bus,
    input  logic [N_OUT*ACC_W-1:0] z_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   err_len,
    output logic                   busy
);

    localparam int LD_W = idx_w(IN);
    localparam int ST_W = idx_w(SETTLE);

    // The SETTLE parameter shadows the state literal, so states are package-scoped.
    ld_state_t              state, state_nx;
    logic [LD_W-1:0]        ld_cnt;
    logic [ST_W-1:0]        st_cnt;
    logic [IN-1:0][WIDTH-1:0] x_q;
    logic                   in_hs, at_end, frame_end, frame_bad;
    logic                   settle_done, cap_en;
    logic                   dr_empty, dr_last_hs;

    assign in_hs       = in_valid & in_ready;
    assign at_end      = (ld_cnt == LD_W'(IN - 1));
    assign frame_end   = in_hs & in_last & at_end;
    assign frame_bad   = in_hs & (in_last ^ at_end);
    assign settle_done = (st_cnt == ST_W'(SETTLE - 1));
    assign x_bus       = x_q;
    assign busy        = (state != fc_ctrl_pkg::LOAD) | ~dr_empty;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= fc_ctrl_pkg::LOAD;
        else        state <= state_nx;
    end

    // Next state: load a good frame, settle, then wait for the drain to free up
    always_comb begin
        state_nx = state;
        unique case (state)
            fc_ctrl_pkg::LOAD:    if (frame_end)   state_nx = fc_ctrl_pkg::SETTLE;
            fc_ctrl_pkg::SETTLE:  if (settle_done) state_nx = fc_ctrl_pkg::CAPTURE;
            fc_ctrl_pkg::CAPTURE: if (cap_en)      state_nx = fc_ctrl_pkg::LOAD;
            default:                               state_nx = fc_ctrl_pkg::LOAD;
        endcase
    end

    // Outputs: accept only in LOAD, capture when the drain empties this cycle or already has
    always_comb begin
        in_ready = (state == fc_ctrl_pkg::LOAD);
        cap_en   = (state == fc_ctrl_pkg::CAPTURE) & (dr_empty | dr_last_hs);
    end

    // Load slot pointer and framing-error pulse; any bad frame restarts at slot 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= frame_bad;
            if (in_hs) ld_cnt <= (frame_end | frame_bad) ? '0 : ld_cnt + LD_W'(1);
        end
    end

    // Settle counter runs only in SETTLE
    always_ff @(posedge clk) begin
        if (!rst_n)                                st_cnt <= '0;
        else if (state == fc_ctrl_pkg::SETTLE)     st_cnt <= st_cnt + ST_W'(1);
        else                                       st_cnt <= '0;
    end

    // Activation bank: the accepted beat lands in the slot ld_cnt points at
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
        end else begin
            for (int k = 0; k < IN; k++)
                if (in_hs && ld_cnt == LD_W'(k)) x_q[k] <= in_data;
        end
    end

    fc_result_drain #(
        .N_OUT (N_OUT),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (cap_en),
        .z_bus     (z_bus),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .empty     (dr_empty),
        .last_hs   (dr_last_hs)
    );

endmodule
